// File: rtl/multi_channel_sync_fifo.sv
// Bank of NUM_CH independent single-clock FIFOs (WIDTH x DEPTH each) sharing one clock/reset.
// Each channel reports its fill level, programmable almost-full/almost-empty flags, sticky
// overflow/underflow flags, and reads either first-word-fall-through (FWFT=1) or through a
// registered output with one cycle of latency (FWFT=0).
//
// Ports (channel c occupies bit c, or slice [c*WIDTH +: WIDTH] / [c*LW +: LW]):
//   w_clk        clock for all channels
//   r_rst        asynchronous active-high reset of all state except the storage arrays
//   wr_en        per-channel write request; wr_data per-channel write word
//   rd_en        per-channel pop request; rd_data/rd_valid per-channel read word and qualifier
//   full, empty, almost_full, almost_empty, level   occupancy status decoded from the count
//   af_thresh, ae_thresh                           shared live thresholds (LW bits, unsigned)
//   overflow, underflow                            sticky error flags, cleared by clr_err
module multi_channel_sync_fifo #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned FWFT   = 1,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LW    = AW + 1
) (
  input  logic                    w_clk,
  input  logic                    r_rst,
  input  logic [NUM_CH-1:0]       wr_en,
  input  logic [NUM_CH*WIDTH-1:0] wr_data,
  input  logic [NUM_CH-1:0]       rd_en,
  output logic [NUM_CH*WIDTH-1:0] rd_data,
  output logic [NUM_CH-1:0]       rd_valid,
  output logic [NUM_CH-1:0]       full,
  output logic [NUM_CH-1:0]       empty,
  output logic [NUM_CH-1:0]       almost_full,
  output logic [NUM_CH-1:0]       almost_empty,
  output logic [NUM_CH*LW-1:0]    level,
  input  logic [LW-1:0]           af_thresh,
  input  logic [LW-1:0]           ae_thresh,
  output logic [NUM_CH-1:0]       overflow,
  output logic [NUM_CH-1:0]       underflow,
  input  logic                    clr_err
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [LW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             is_full, is_empty;
    logic             wr_acc, rd_acc;

    assign is_full  = (count_q == LW'(DEPTH));
    assign is_empty = (count_q == '0);
    // A write to a full channel is dropped even when a read frees a slot this cycle.
    assign wr_acc   = wr_en[c] && !is_full;
    assign rd_acc   = rd_en[c] && !is_empty;

    always_comb begin
      count_d = count_q;
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + LW'(1);
        2'b01:   count_d = count_q - LW'(1);
        default: count_d = count_q;
      endcase
    end

    // A new error in the same cycle as clr_err takes priority so no event is lost.
    always_comb begin
      ovf_d = ovf_q;
      unf_d = unf_q;
      if (clr_err) begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end
      if (wr_en[c] && is_full)  ovf_d = 1'b1;
      if (rd_en[c] && is_empty) unf_d = 1'b1;
    end

    // Storage is intentionally not reset; stale words are hidden by the empty mask.
    always_ff @(posedge w_clk) begin
      if (wr_acc) mem_q[wptr_q] <= wr_data[c*WIDTH +: WIDTH];
    end

    always_ff @(posedge w_clk or posedge r_rst) begin
      if (r_rst) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
        ovf_q   <= 1'b0;
        unf_q   <= 1'b0;
      end else begin
        if (wr_acc) wptr_q <= wptr_q + AW'(1);
        if (rd_acc) rptr_q <= rptr_q + AW'(1);
        count_q <= count_d;
        ovf_q   <= ovf_d;
        unf_q   <= unf_d;
      end
    end

    assign full[c]              = is_full;
    assign empty[c]             = is_empty;
    assign level[c*LW +: LW]    = count_q;
    assign almost_full[c]       = (count_q >= af_thresh);
    assign almost_empty[c]      = (count_q <= ae_thresh);
    assign overflow[c]          = ovf_q;
    assign underflow[c]         = unf_q;

    if (FWFT != 0) begin : g_fwft
      assign rd_valid[c]             = !is_empty;
      assign rd_data[c*WIDTH +: WIDTH] = is_empty ? '0 : mem_q[rptr_q];
    end else begin : g_reg
      logic [WIDTH-1:0] rdata_q;
      logic             rvalid_q;

      always_ff @(posedge w_clk or posedge r_rst) begin
        if (r_rst) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rvalid_q <= rd_acc;
          if (rd_acc) rdata_q <= mem_q[rptr_q];
        end
      end

      assign rd_valid[c]               = rvalid_q;
      assign rd_data[c*WIDTH +: WIDTH] = rdata_q;
    end
  end

endmodule

// File: tb/tb_multi_channel_sync_fifo.sv
// Self-checking bench: one FWFT and one registered-read instance share all stimulus; both are
// compared every cycle against a queue-based model, plus directed checks on key events.
module tb_multi_channel_sync_fifo;
  localparam int unsigned WIDTH  = 16;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned NUM_CH = 2;
  localparam int unsigned LW     = $clog2(DEPTH) + 1;

  logic                    w_clk = 1'b0;
  logic                    r_rst;
  logic [NUM_CH-1:0]       wr_en, rd_en;
  logic [NUM_CH*WIDTH-1:0] wr_data;
  logic [LW-1:0]           af_thresh, ae_thresh;
  logic                    clr_err;

  logic [NUM_CH*WIDTH-1:0] rd_data_f, rd_data_r;
  logic [NUM_CH-1:0]       rd_valid_f, rd_valid_r, full_f, full_r, empty_f, empty_r;
  logic [NUM_CH-1:0]       af_f, af_r, ae_f, ae_r, ovf_f, ovf_r, unf_f, unf_r;
  logic [NUM_CH*LW-1:0]    level_f, level_r;

  int checks = 0;
  int failures = 0;

  always #5 w_clk = ~w_clk;

  multi_channel_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_CH(NUM_CH), .FWFT(1)) u_fwft (
    .w_clk(w_clk), .r_rst(r_rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data_f), .rd_valid(rd_valid_f), .full(full_f), .empty(empty_f),
    .almost_full(af_f), .almost_empty(ae_f), .level(level_f), .af_thresh(af_thresh),
    .ae_thresh(ae_thresh), .overflow(ovf_f), .underflow(unf_f), .clr_err(clr_err)
  );

  multi_channel_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_CH(NUM_CH), .FWFT(0)) u_reg (
    .w_clk(w_clk), .r_rst(r_rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data_r), .rd_valid(rd_valid_r), .full(full_r), .empty(empty_r),
    .almost_full(af_r), .almost_empty(ae_r), .level(level_r), .af_thresh(af_thresh),
    .ae_thresh(ae_thresh), .overflow(ovf_r), .underflow(unf_r), .clr_err(clr_err)
  );

  // Reference model: one queue of words per channel plus flag/register state.
  logic [WIDTH-1:0] mq [NUM_CH][$];
  bit               m_ovf [NUM_CH];
  bit               m_unf [NUM_CH];
  bit               m_vld [NUM_CH];
  logic [WIDTH-1:0] m_rdat [NUM_CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      mq[c].delete();
      m_ovf[c]  = 1'b0;
      m_unf[c]  = 1'b0;
      m_vld[c]  = 1'b0;
      m_rdat[c] = '0;
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < NUM_CH; c++) begin
      int n = mq[c].size();
      bit was_full = (n == DEPTH);
      bit was_empty = (n == 0);
      m_vld[c] = 1'b0;
      if (rd_en[c] && !was_empty) begin
        m_rdat[c] = mq[c].pop_front();
        m_vld[c]  = 1'b1;
      end
      if (wr_en[c] && !was_full) mq[c].push_back(wr_data[c*WIDTH +: WIDTH]);
      if (wr_en[c] && was_full) m_ovf[c] = 1'b1;
      else if (clr_err) m_ovf[c] = 1'b0;
      if (rd_en[c] && was_empty) m_unf[c] = 1'b1;
      else if (clr_err) m_unf[c] = 1'b0;
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < NUM_CH; c++) begin
      int n = mq[c].size();
      logic [WIDTH-1:0] head = (n != 0) ? mq[c][0] : '0;
      chk($sformatf("level_f%0d", c), level_f[c*LW +: LW], n);
      chk($sformatf("level_r%0d", c), level_r[c*LW +: LW], n);
      chk($sformatf("full_f%0d", c), full_f[c], (n == DEPTH));
      chk($sformatf("full_r%0d", c), full_r[c], (n == DEPTH));
      chk($sformatf("empty_f%0d", c), empty_f[c], (n == 0));
      chk($sformatf("empty_r%0d", c), empty_r[c], (n == 0));
      chk($sformatf("af_f%0d", c), af_f[c], (n >= int'(af_thresh)));
      chk($sformatf("af_r%0d", c), af_r[c], (n >= int'(af_thresh)));
      chk($sformatf("ae_f%0d", c), ae_f[c], (n <= int'(ae_thresh)));
      chk($sformatf("ae_r%0d", c), ae_r[c], (n <= int'(ae_thresh)));
      chk($sformatf("ovf_f%0d", c), ovf_f[c], m_ovf[c]);
      chk($sformatf("ovf_r%0d", c), ovf_r[c], m_ovf[c]);
      chk($sformatf("unf_f%0d", c), unf_f[c], m_unf[c]);
      chk($sformatf("unf_r%0d", c), unf_r[c], m_unf[c]);
      chk($sformatf("rvalid_f%0d", c), rd_valid_f[c], (n != 0));
      chk($sformatf("rdata_f%0d", c), rd_data_f[c*WIDTH +: WIDTH], head);
      chk($sformatf("rvalid_r%0d", c), rd_valid_r[c], m_vld[c]);
      chk($sformatf("rdata_r%0d", c), rd_data_r[c*WIDTH +: WIDTH], m_rdat[c]);
    end
  endtask

  // Advance one edge; inputs were set after the previous edge and stay stable across this one.
  task automatic cycle();
    @(posedge w_clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Reset asserted between edges: outputs must reach reset values before any clock edge.
  task automatic reset_mid_op();
    #2;
    r_rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge w_clk);
    #1;
    r_rst = 1'b0;
    check_all();
  endtask

  initial begin
    r_rst     = 1'b1;
    wr_en     = '0;
    rd_en     = '0;
    wr_data   = '0;
    clr_err   = 1'b0;
    af_thresh = '0;
    ae_thresh = '0;
    #1;
    model_reset();
    check_all();
    chk("reset_af_thresh0", af_f, 2'b11);
    chk("reset_empty", empty_f, 2'b11);
    @(posedge w_clk);
    #1;
    r_rst     = 1'b0;
    af_thresh = LW'(14);
    ae_thresh = LW'(2);

    // Fill channel 0 and overflow it.
    wr_en = 2'b01;
    for (int i = 1; i <= 16; i++) begin
      wr_data[15:0] = 16'(i);
      cycle();
    end
    chk("fill_full0", full_f[0], 1'b1);
    chk("fill_level0", level_f[LW-1:0], 16);
    wr_data[15:0] = 16'h0011;
    cycle();
    chk("fill_ovf0", ovf_f[0], 1'b1);
    chk("fill_ch1_empty", empty_f[1], 1'b1);
    chk("fill_ch1_level", level_f[LW +: LW], 0);
    wr_en = '0;

    // Drain channel 0 in order, then underflow and clear errors.
    rd_en = 2'b01;
    for (int i = 1; i <= 16; i++) begin
      chk("drain_fwft", rd_data_f[15:0], i);
      cycle();
      chk("drain_reg", rd_data_r[15:0], i);
    end
    chk("drain_empty0", empty_f[0], 1'b1);
    cycle();
    chk("drain_unf0", unf_f[0], 1'b1);
    chk("drain_rdata0", rd_data_f[15:0], 0);
    rd_en   = '0;
    clr_err = 1'b1;
    cycle();
    clr_err = 1'b0;
    chk("clr_ovf0", ovf_f[0], 1'b0);
    chk("clr_unf0", unf_f[0], 1'b0);

    // Wrap-around on channel 1 at a steady level of 8.
    wr_en = 2'b10;
    for (int j = 0; j < 8; j++) begin
      wr_data[31:16] = 16'(16'h0100 + j);
      cycle();
    end
    rd_en = 2'b10;
    for (int k = 0; k < 24; k++) begin
      wr_data[31:16] = 16'(16'h0108 + k);
      chk("wrap_data", rd_data_f[31:16], 16'h0100 + k);
      cycle();
      chk("wrap_level", level_f[LW +: LW], 8);
    end
    wr_en = '0;
    rd_en = '0;

    // Threshold crossings on channel 0.
    af_thresh = LW'(12);
    ae_thresh = LW'(3);
    wr_en = 2'b01;
    for (int i = 1; i <= 12; i++) begin
      wr_data[15:0] = 16'(16'h0A00 + i);
      cycle();
      if (i == 3)  chk("ae_at3", ae_f[0], 1'b1);
      if (i == 4)  chk("ae_at4", ae_f[0], 1'b0);
      if (i == 11) chk("af_at11", af_f[0], 1'b0);
      if (i == 12) chk("af_at12", af_f[0], 1'b1);
    end
    wr_en = '0;
    af_thresh = LW'(16);
    #1;
    chk("af_live16", af_f[0], 1'b0);
    check_all();
    af_thresh = LW'(17);
    ae_thresh = LW'(16);
    #1;
    chk("af_above_depth", af_f, 2'b00);
    chk("ae_at_depth", ae_f, 2'b11);
    af_thresh = LW'(12);
    ae_thresh = LW'(3);

    // Bring channel 0 to level 5 and overflow channel 1, then reset mid-operation.
    rd_en = 2'b01;
    for (int i = 0; i < 7; i++) cycle();
    rd_en = '0;
    wr_en = 2'b10;
    for (int i = 0; i < 9; i++) begin
      wr_data[31:16] = 16'(16'h0C00 + i);
      cycle();
    end
    wr_en = '0;
    chk("pre_rst_level0", level_f[LW-1:0], 5);
    chk("pre_rst_ovf1", ovf_f[1], 1'b1);
    reset_mid_op();
    chk("rst_level0", level_f[LW-1:0], 0);
    chk("rst_ovf1", ovf_f[1], 1'b0);
    wr_en = 2'b01;
    wr_data[15:0] = 16'h1234;
    cycle();
    wr_en = '0;
    chk("post_rst_data", rd_data_f[15:0], 16'h1234);

    // Registered read mode latency on channel 1.
    wr_en = 2'b10;
    wr_data[31:16] = 16'hBEEF;
    cycle();
    wr_en = '0;
    rd_en = 2'b10;
    cycle();
    chk("reg_valid_k1", rd_valid_r[1], 1'b1);
    chk("reg_data_k1", rd_data_r[31:16], 16'hBEEF);
    rd_en = '0;
    cycle();
    chk("reg_valid_k2", rd_valid_r[1], 1'b0);
    chk("reg_data_k2", rd_data_r[31:16], 16'hBEEF);

    // Randomised traffic with phases biased toward full, empty and balanced operation.
    for (int i = 0; i < 600; i++) begin
      int wp;
      int phase = (i / 100) % 3;
      wp = (phase == 0) ? 80 : ((phase == 1) ? 20 : 50);
      for (int c = 0; c < NUM_CH; c++) begin
        wr_en[c] = ($urandom_range(0, 99) < wp);
        rd_en[c] = ($urandom_range(0, 99) < (100 - wp));
      end
      wr_data = $urandom;
      clr_err = ($urandom_range(0, 19) == 0);
      if (i % 50 == 0) begin
        af_thresh = LW'($urandom_range(0, 20));
        ae_thresh = LW'($urandom_range(0, 20));
      end
      if (i == 333) reset_mid_op();
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
